// File: rtl/spi_pkg.sv
// Constants and the master state encoding, shared by the SPI master and the slave-side logic.
package spi_pkg;

    localparam int BYTE_SIZE    = 8;
    localparam int PACKET_SIZE  = 8;
    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        HOLD,
        GAP
    } spiState_t;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI pins of the master, bundled for port connection.
interface spi_master_if #(
    parameter int N = spi_pkg::BYTE_SIZE * spi_pkg::PACKET_SIZE
);

    logic         startIn;
    logic [N-1:0] dataIn;
    logic [N-1:0] dataOut;
    logic         doneOut;
    logic         busyOut;
    logic         ssOut;
    logic         sckOut;
    logic         mosiOut;
    logic         misoIn;

    modport master (
        input  startIn, dataIn, misoIn,
        output dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
    );

    modport slave (
        output startIn, dataIn, misoIn,
        input  dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
    );

endinterface

// File: rtl/spi_sck_divider.sv
// Phase timer: one-cycle tick every CLK_DIV cycles while enabled, restarting whenever disabled.
module spi_sck_divider #(
    parameter int CLK_DIV = 8
) (
    input  logic clkIn,
    input  logic resetIn,
    input  logic enIn,
    output logic tickOut
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clkIn) begin
        if (resetIn || !enIn || tickOut) begin
            count <= RELOAD;
        end else begin
            count <= count - 8'd1;
        end
    end

    assign tickOut = enIn && (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one N-bit packet out MSB first while capturing the slave's reply.
//
// state    | meaning
// IDLE     | waiting for startIn, SS high
// SETUP    | SS low, first MOSI bit settling before the first rising SCK
// SCK_HIGH | SCK high; MISO sampled on the last cycle
// SCK_LOW  | SCK low; MOSI advanced on entry
// HOLD     | SS held low after the last SCK falling edge
// GAP      | SS high minimum time; dataOut updated and doneOut pulsed on entry
module spi_master
    import spi_pkg::*;
#(
    parameter int PACKET_SIZE = spi_pkg::PACKET_SIZE,
    parameter int BYTE_SIZE   = spi_pkg::BYTE_SIZE,
    parameter int CLK_DIV     = 8   // legal range 4..255
) (
    input logic          clkIn,
    input logic          resetIn,
    spi_master_if.master bus
);

    localparam int N     = BYTE_SIZE * PACKET_SIZE;
    localparam int CNT_W = $clog2(N + 1);

    spiState_t          state;
    spiState_t          stateNext;
    logic               tick;
    logic [N-1:0]       txShift;
    logic [N-1:0]       rxShift;
    logic [N-1:0]       dataReg;
    logic [CNT_W-1:0]   bitCnt;
    logic               misoMeta;
    logic               misoSync;
    logic               ssReg;
    logic               sckReg;
    logic               doneReg;
    logic               busyReg;

    spi_sck_divider #(.CLK_DIV(CLK_DIV)) uDiv (
        .clkIn   (clkIn),
        .resetIn (resetIn),
        .enIn    (state != IDLE),
        .tickOut (tick)
    );

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (bus.startIn) stateNext = SETUP;
            SETUP:    if (tick) stateNext = SCK_HIGH;
            SCK_HIGH: if (tick) stateNext = SCK_LOW;
            SCK_LOW:  if (tick) stateNext = (bitCnt == CNT_W'(N)) ? HOLD : SCK_HIGH;
            HOLD:     if (tick) stateNext = GAP;
            GAP:      if (tick) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they switch cleanly with the state.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            txShift  <= '0;
            rxShift  <= '0;
            dataReg  <= '0;
            bitCnt   <= '0;
            misoMeta <= 1'b0;
            misoSync <= 1'b0;
            ssReg    <= 1'b1;
            sckReg   <= 1'b0;
            doneReg  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            misoMeta <= bus.misoIn;
            misoSync <= misoMeta;
            sckReg   <= (stateNext == SCK_HIGH);
            ssReg    <= (stateNext == IDLE) || (stateNext == GAP);
            busyReg  <= (stateNext != IDLE);
            doneReg  <= (state == HOLD) && tick;

            if ((state == IDLE) && bus.startIn) begin
                txShift <= bus.dataIn;
                rxShift <= '0;
                bitCnt  <= '0;
            end else if ((state == SCK_HIGH) && tick) begin
                txShift <= {txShift[N-2:0], 1'b0};
                rxShift <= {rxShift[N-2:0], misoSync};
                bitCnt  <= bitCnt + CNT_W'(1);
            end

            if ((state == HOLD) && tick) begin
                dataReg <= rxShift;
            end
        end
    end

    assign bus.ssOut   = ssReg;
    assign bus.sckOut  = sckReg;
    assign bus.mosiOut = txShift[N-1] & ~ssReg;
    assign bus.doneOut = doneReg;
    assign bus.busyOut = busyReg;
    assign bus.dataOut = dataReg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard on doneOut/dataOut plus per-transfer pin timing checks.
module tb_spi_master;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] misoMode;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [N-1:0] expQ0[$];
    logic [N-1:0] expQ1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_if #(.N(N)) bus0();
    spi_master_if #(.N(N)) bus1();

    assign bus0.misoIn = (misoMode == 2'd2) ? bus0.mosiOut : misoMode[0];
    assign bus1.misoIn = bus1.mosiOut;

    spi_master #(.PACKET_SIZE(8), .BYTE_SIZE(8), .CLK_DIV(4)) dut0 (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus0.master)
    );

    spi_master #(.PACKET_SIZE(8), .BYTE_SIZE(8), .CLK_DIV(8)) dut1 (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus1.master)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every doneOut pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus0.doneOut) begin
            if (expQ0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected doneOut cycle=%0d dataOut=%h expected=none", cyc, bus0.dataOut);
            end else begin
                check("dut0 dataOut", bus0.dataOut, expQ0.pop_front());
            end
        end
        if (!rst && bus1.doneOut) begin
            if (expQ1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected doneOut cycle=%0d dataOut=%h expected=none", cyc, bus1.dataOut);
            end else begin
                check("dut1 dataOut", bus1.dataOut, expQ1.pop_front());
            end
        end
    end

    task automatic runTransfer(input logic [N-1:0] data, input logic [N-1:0] exp, input bit extraStarts);
        int tStart;
        int doneCyc = -1;
        int doneCnt = 0;
        int rises = 0;
        int ssLow = 0;
        int firstLow = -1;
        int lastLow = -1;
        int mosiErr = 0;
        int ssHighMosi = 0;
        int idleCyc = -1;
        bit prevSck = 1'b0;

        @(negedge clk);
        bus0.dataIn  = data;
        bus0.startIn = 1'b1;
        expQ0.push_back(exp);
        tStart = cyc;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus0.startIn = 1'b0;
            bus0.dataIn  = ~data;
            if (extraStarts && (cyc == tStart + 511 || cyc == tStart + 521 || cyc == tStart + 522)) begin
                bus0.startIn = 1'b1;
                bus0.dataIn  = 64'h1111_2222_3333_4444;
            end
            if (bus0.sckOut && !prevSck) begin
                if (rises < N && bus0.mosiOut !== data[N-1-rises]) mosiErr++;
                rises++;
            end
            prevSck = bus0.sckOut;
            if (!bus0.ssOut) begin
                ssLow++;
                if (firstLow < 0) firstLow = cyc;
                lastLow = cyc;
            end else if (bus0.mosiOut) begin
                ssHighMosi++;
            end
            if (bus0.doneOut) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (!bus0.busyOut) begin
                idleCyc = cyc;
                break;
            end
        end
        bus0.startIn = 1'b0;

        check("doneLatency", 64'(doneCyc - tStart), 64'd521);
        check("doneCount", 64'(doneCnt), 64'd1);
        check("sckRises", 64'(rises), 64'd64);
        check("firstSsLow", 64'(firstLow - tStart), 64'd1);
        check("lastSsLow", 64'(lastLow - tStart), 64'd520);
        check("ssLowCycles", 64'(ssLow), 64'd520);
        check("mosiBitErrors", 64'(mosiErr), 64'd0);
        check("mosiWhileSsHigh", 64'(ssHighMosi), 64'd0);
        check("busyLowCycle", 64'(idleCyc - tStart), 64'd525);

        repeat (10) @(negedge clk);
        check("dataOutHold", bus0.dataOut, exp);
        check("busyAfterIdle", 64'(bus0.busyOut), 64'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tStart;
        bit doneSeen;
        rst          = 1'b1;
        misoMode     = 2'd0;
        bus0.startIn = 1'b0;
        bus0.dataIn  = '0;
        bus1.startIn = 1'b0;
        bus1.dataIn  = '0;
        bus0.startIn = 1'b1;
        repeat (3) @(negedge clk);
        check("resetSs", 64'(bus0.ssOut), 64'd1);
        check("resetSck", 64'(bus0.sckOut), 64'd0);
        check("resetMosi", 64'(bus0.mosiOut), 64'd0);
        check("resetDone", 64'(bus0.doneOut), 64'd0);
        check("resetBusy", 64'(bus0.busyOut), 64'd0);
        check("resetDataOut", bus0.dataOut, 64'd0);
        bus0.startIn = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        misoMode = 2'd1;
        runTransfer(64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        misoMode = 2'd0;
        runTransfer(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0000, 1'b0);
        misoMode = 2'd2;
        runTransfer(64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        // Abort mid-transfer; no doneOut may follow and dataOut clears.
        @(negedge clk);
        bus0.dataIn  = 64'h0F0F_0F0F_0F0F_0F0F;
        bus0.startIn = 1'b1;
        tStart = cyc;
        for (int i = 0; i < 300 && cyc < tStart + 200; i++) begin
            @(negedge clk);
            bus0.startIn = 1'b0;
        end
        check("busyBeforeAbort", 64'(bus0.busyOut), 64'd1);
        rst = 1'b1;
        bus0.startIn = 1'b1;
        @(negedge clk);
        check("abortSs", 64'(bus0.ssOut), 64'd1);
        check("abortSck", 64'(bus0.sckOut), 64'd0);
        check("abortBusy", 64'(bus0.busyOut), 64'd0);
        check("abortDone", 64'(bus0.doneOut), 64'd0);
        check("abortMosi", 64'(bus0.mosiOut), 64'd0);
        check("abortDataOut", bus0.dataOut, 64'd0);
        rst = 1'b0;
        bus0.startIn = 1'b0;
        repeat (600) @(negedge clk);
        check("idleAfterAbort", 64'(bus0.busyOut), 64'd0);

        runTransfer(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);

        @(negedge clk);
        bus1.dataIn  = 64'h0123_4567_89AB_CDEF;
        bus1.startIn = 1'b1;
        expQ1.push_back(64'h0123_4567_89AB_CDEF);
        tStart = cyc;
        doneSeen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus1.startIn = 1'b0;
            bus1.dataIn  = '0;
            if (bus1.doneOut) begin
                doneSeen = 1'b1;
                break;
            end
        end
        check("dut1DoneSeen", 64'(doneSeen), 64'd1);
        check("dut1DoneLatency", 64'(cyc - tStart), 64'd1041);

        repeat (5) @(negedge clk);
        check("queue0Drained", 64'(expQ0.size()), 64'd0);
        check("queue1Drained", 64'(expQ1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
